// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, single-cycle ALU with {Z,N} flags, branch/jump
// resolution, and an iterative shift-add / restoring-divide unit that stalls the front end.
`timescale 1ns/1ps
module execute_stage #(
  parameter int WIDTH     = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_flush_in,
  input  logic             ex_hold,
  input  logic [WIDTH-1:0] ex_PC_next,
  input  logic [WIDTH-1:0] ex_reg_1_data,
  input  logic [WIDTH-1:0] ex_reg_2_data,
  input  logic [WIDTH-1:0] ex_imm,
  input  logic [1:0]       ex_fwd_1_sel,
  input  logic [1:0]       ex_fwd_2_sel,
  input  logic [WIDTH-1:0] ex_fwd_mem_data,
  input  logic [WIDTH-1:0] ex_fwd_wb_data,
  input  logic [1:0]       ex_ALU_src,
  input  logic [4:0]       ex_ALU_OP,
  input  logic             ex_Branch,
  input  logic [1:0]       ex_br_cond,
  input  logic             ex_Jump,
  input  logic [1:0]       ex_FL,
  output logic [WIDTH-1:0] ex_result,
  output logic [WIDTH-1:0] ex_store_data,
  output logic [1:0]       ex_FL_new,
  output logic             ex_redirect,
  output logic [WIDTH-1:0] ex_target,
  output logic             ex_stall,
  output logic             ex_md_busy
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(MD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_CYCLES - 1);

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_AND = 5'd2,  OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4,  OP_NOT = 5'd5,  OP_SLL = 5'd6,  OP_SRL  = 5'd7;
  localparam logic [4:0] OP_SRA = 5'd8,  OP_CMP = 5'd9,  OP_PASSB = 5'd10;
  localparam logic [4:0] OP_MUL = 5'd16, OP_DIV = 5'd17, OP_REM = 5'd18;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} md_state_t;

  md_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              md_busy_q, md_busy_d;
  logic [WIDTH-1:0]  md_a_q, md_a_d;
  logic [WIDTH-1:0]  md_b_q, md_b_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [4:0]        kind_q, kind_d;

  logic [WIDTH-1:0]        rs1_fwd, rs2_fwd, op_a, op_b, alu_res, md_res;
  logic signed [WIDTH-1:0] op_a_s;
  logic [SH_W-1:0]         shamt;
  logic                    is_md, cond_ok;
  logic [WIDTH:0]          rem_shift, rem_diff;

  always_comb begin
    unique case (ex_fwd_1_sel)
      2'b01:   rs1_fwd = ex_fwd_mem_data;
      2'b10:   rs1_fwd = ex_fwd_wb_data;
      default: rs1_fwd = ex_reg_1_data;
    endcase
    unique case (ex_fwd_2_sel)
      2'b01:   rs2_fwd = ex_fwd_mem_data;
      2'b10:   rs2_fwd = ex_fwd_wb_data;
      default: rs2_fwd = ex_reg_2_data;
    endcase
    unique case (ex_ALU_src)
      2'b00:   begin op_a = rs1_fwd;    op_b = rs2_fwd; end
      2'b01:   begin op_a = rs1_fwd;    op_b = ex_imm;  end
      2'b10:   begin op_a = ex_PC_next; op_b = ex_imm;  end
      default: begin op_a = rs1_fwd;    op_b = '0;      end
    endcase
  end

  assign op_a_s = op_a;
  assign shamt  = op_b[SH_W-1:0];
  assign is_md  = (ex_ALU_OP == OP_MUL) || (ex_ALU_OP == OP_DIV) || (ex_ALU_OP == OP_REM);

  always_comb begin
    alu_res = '0;
    case (ex_ALU_OP)
      OP_ADD:   alu_res = op_a + op_b;
      OP_SUB:   alu_res = op_a - op_b;
      OP_AND:   alu_res = op_a & op_b;
      OP_OR:    alu_res = op_a | op_b;
      OP_XOR:   alu_res = op_a ^ op_b;
      OP_NOT:   alu_res = ~op_a;
      OP_SLL:   alu_res = op_a << shamt;
      OP_SRL:   alu_res = op_a >> shamt;
      OP_SRA:   alu_res = op_a_s >>> shamt;
      OP_CMP:   alu_res = op_a - op_b;
      OP_PASSB: alu_res = op_b;
      default:  alu_res = '0;
    endcase
  end

  // Restoring divide: remainder lives in acc_q, dividend shifts out of md_a_q as quotient shifts in
  assign rem_shift = {acc_q, md_a_q[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, md_b_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_a_d   = md_a_q;
    md_b_d   = md_b_q;
    acc_d    = acc_q;
    kind_d   = kind_q;
    ex_stall = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_md && !ex_flush_in) begin
          ex_stall = 1'b1;
          md_a_d   = op_a;
          md_b_d   = op_b;
          acc_d    = '0;
          cnt_d    = '0;
          kind_d   = ex_ALU_OP;
          if ((ex_ALU_OP != OP_MUL) && (op_b == '0)) begin
            md_a_d  = '1;
            acc_d   = op_a;
            state_d = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (ex_flush_in) begin
          state_d = S_IDLE;
        end else begin
          ex_stall = 1'b1;
          if (kind_q == OP_MUL) begin
            if (md_b_q[0]) acc_d = acc_q + md_a_q;
            md_a_d = md_a_q << 1;
            md_b_d = md_b_q >> 1;
          end else if (!rem_diff[WIDTH]) begin
            acc_d  = rem_diff[WIDTH-1:0];
            md_a_d = {md_a_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d  = rem_shift[WIDTH-1:0];
            md_a_d = {md_a_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (ex_flush_in || !ex_hold) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    md_busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      md_busy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      md_busy_q <= md_busy_d;
    end
  end

  always_ff @(posedge clk) begin
    md_a_q <= md_a_d;
    md_b_q <= md_b_d;
    acc_q  <= acc_d;
    kind_q <= kind_d;
  end

  assign md_res = (kind_q == OP_DIV) ? md_a_q : acc_q;

  always_comb begin
    unique case (ex_br_cond)
      2'b00:   cond_ok = 1'b1;
      2'b01:   cond_ok = ex_FL[1];
      2'b10:   cond_ok = !ex_FL[1];
      default: cond_ok = ex_FL[0];
    endcase
  end

  assign ex_result     = (state_q == S_DONE) ? md_res : alu_res;
  assign ex_FL_new     = {(ex_result == '0), ex_result[WIDTH-1]};
  assign ex_store_data = rs2_fwd;
  assign ex_redirect   = !ex_stall && !ex_flush_in && (ex_Jump || (ex_Branch && cond_ok));
  assign ex_target     = ex_Jump ? rs1_fwd : (ex_PC_next + ex_imm);
  assign ex_md_busy    = md_busy_q;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: driver issues ops and queues model results,
// a negedge monitor pops and compares whenever an op leaves Execute.
`timescale 1ns/1ps
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_flush_in, ex_hold;
  logic [31:0] ex_PC_next, ex_reg_1_data, ex_reg_2_data, ex_imm;
  logic [1:0]  ex_fwd_1_sel, ex_fwd_2_sel;
  logic [31:0] ex_fwd_mem_data, ex_fwd_wb_data;
  logic [1:0]  ex_ALU_src;
  logic [4:0]  ex_ALU_OP;
  logic        ex_Branch, ex_Jump;
  logic [1:0]  ex_br_cond, ex_FL;
  logic [31:0] ex_result, ex_store_data, ex_target;
  logic [1:0]  ex_FL_new;
  logic        ex_redirect, ex_stall, ex_md_busy;

  execute_stage #(.WIDTH(32), .MD_CYCLES(32)) dut (
    .clk(clk), .rst_n(rst_n), .ex_flush_in(ex_flush_in), .ex_hold(ex_hold),
    .ex_PC_next(ex_PC_next), .ex_reg_1_data(ex_reg_1_data), .ex_reg_2_data(ex_reg_2_data),
    .ex_imm(ex_imm), .ex_fwd_1_sel(ex_fwd_1_sel), .ex_fwd_2_sel(ex_fwd_2_sel),
    .ex_fwd_mem_data(ex_fwd_mem_data), .ex_fwd_wb_data(ex_fwd_wb_data),
    .ex_ALU_src(ex_ALU_src), .ex_ALU_OP(ex_ALU_OP), .ex_Branch(ex_Branch),
    .ex_br_cond(ex_br_cond), .ex_Jump(ex_Jump), .ex_FL(ex_FL),
    .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_FL_new(ex_FL_new),
    .ex_redirect(ex_redirect), .ex_target(ex_target), .ex_stall(ex_stall),
    .ex_md_busy(ex_md_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  aop;
    logic [31:0] r1, r2, imm, pc, mem, wb;
    logic [1:0]  src, fwd1, fwd2, cond, fl;
    logic        br, jmp;
  } op_t;

  typedef struct {
    logic [31:0] res, tgt, st;
    logic [1:0]  fl;
    logic        redir;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic active = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic op_t mk(input logic [4:0] aop, input logic [31:0] r1, input logic [31:0] r2,
                             input logic [31:0] imm, input logic [1:0] src);
    op_t o;
    o.aop = aop; o.r1 = r1; o.r2 = r2; o.imm = imm; o.src = src;
    o.pc = 32'h0; o.mem = 32'h0; o.wb = 32'h0;
    o.fwd1 = 2'b00; o.fwd2 = 2'b00; o.cond = 2'b00; o.fl = 2'b00;
    o.br = 1'b0; o.jmp = 1'b0;
    return o;
  endfunction

  // Reference: straight from the instruction-level rules, no FSM
  function automatic exp_t model(input op_t o);
    exp_t e;
    logic [31:0] a1, b1, A, B;
    logic [63:0] prod;
    logic signed [31:0] sa;
    logic taken;
    a1 = (o.fwd1 == 2'b01) ? o.mem : (o.fwd1 == 2'b10) ? o.wb : o.r1;
    b1 = (o.fwd2 == 2'b01) ? o.mem : (o.fwd2 == 2'b10) ? o.wb : o.r2;
    case (o.src)
      2'b00:   begin A = a1;   B = b1;    end
      2'b01:   begin A = a1;   B = o.imm; end
      2'b10:   begin A = o.pc; B = o.imm; end
      default: begin A = a1;   B = 32'h0; end
    endcase
    sa   = A;
    prod = {32'h0, A} * {32'h0, B};
    case (o.aop)
      5'd0:  e.res = A + B;
      5'd1:  e.res = A - B;
      5'd2:  e.res = A & B;
      5'd3:  e.res = A | B;
      5'd4:  e.res = A ^ B;
      5'd5:  e.res = ~A;
      5'd6:  e.res = A << B[4:0];
      5'd7:  e.res = A >> B[4:0];
      5'd8:  e.res = sa >>> B[4:0];
      5'd9:  e.res = A - B;
      5'd10: e.res = B;
      5'd16: e.res = prod[31:0];
      5'd17: e.res = (B == 0) ? 32'hFFFF_FFFF : A / B;
      5'd18: e.res = (B == 0) ? A : A % B;
      default: e.res = 32'h0;
    endcase
    e.fl = {(e.res == 32'h0), e.res[31]};
    taken = o.jmp || (o.br && ((o.cond == 2'b00) || (o.cond == 2'b01 && o.fl[1]) ||
                               (o.cond == 2'b10 && !o.fl[1]) || (o.cond == 2'b11 && o.fl[0])));
    e.redir = taken;
    e.tgt   = o.jmp ? a1 : o.pc + o.imm;
    e.st    = b1;
    return e;
  endfunction

  task automatic drive(input op_t o);
    ex_ALU_OP = o.aop; ex_reg_1_data = o.r1; ex_reg_2_data = o.r2; ex_imm = o.imm;
    ex_ALU_src = o.src; ex_PC_next = o.pc; ex_fwd_mem_data = o.mem; ex_fwd_wb_data = o.wb;
    ex_fwd_1_sel = o.fwd1; ex_fwd_2_sel = o.fwd2; ex_br_cond = o.cond; ex_FL = o.fl;
    ex_Branch = o.br; ex_Jump = o.jmp;
  endtask

  // Issue one op, count its stall cycles, optionally hold it in DONE for hold_n cycles
  task automatic run_op(input string name, input op_t o, input int exp_stalls, input int hold_n);
    exp_t e;
    int n;
    e = model(o);
    drive(o);
    ex_hold = (hold_n > 0);
    active  = 1'b1;
    sb.push_back(e);
    n = 0;
    @(negedge clk);
    while (ex_stall) begin
      n++;
      if (n > 200) begin
        fails++; tests++;
        $display("FAIL %s_timeout: stall still high after %0d cycles", name, n);
        break;
      end
      @(negedge clk);
    end
    chk({name, "_stall_cycles"}, n, exp_stalls);
    for (int i = 0; i < hold_n; i++) begin
      chk({name, "_hold_result"}, ex_result, e.res);
      @(posedge clk); #1;
      if (i == hold_n - 1) ex_hold = 1'b0;
      @(negedge clk);
    end
    @(posedge clk); #1;
    active = 1'b0;
  endtask

  task automatic nop();
    drive(mk(5'd0, 32'h0, 32'h0, 32'h0, 2'b00));
    active = 1'b0;
  endtask

  // Monitor: an op leaves Execute on any cycle that is not stalled, held or flushed
  always @(negedge clk) begin
    if (rst_n && active && !ex_stall && !ex_hold && !ex_flush_in) begin
      exp_t e;
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb_underflow: got result 0x%08h with no expected entry", ex_result);
      end else begin
        e = sb.pop_front();
        chk("result",   ex_result,     e.res);
        chk("flags",    {30'h0, ex_FL_new}, {30'h0, e.fl});
        chk("redirect", {31'h0, ex_redirect}, {31'h0, e.redir});
        chk("store",    ex_store_data, e.st);
        if (e.redir) chk("target", ex_target, e.tgt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t o;
    ex_flush_in = 1'b0; ex_hold = 1'b0; rst_n = 1'b0;
    nop();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_md_busy",  {31'h0, ex_md_busy},  32'h0);
    chk("rst_stall",    {31'h0, ex_stall},    32'h0);
    chk("rst_redirect", {31'h0, ex_redirect}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Overflowing ADD sets N
    run_op("add_ovf", mk(5'd0, 32'h7FFF_FFFF, 32'h1, 32'h0, 2'b00), 0, 0);

    // Forwarded SUB to zero, then a taken EQ branch
    o = mk(5'd1, 32'd9, 32'd5, 32'h0, 2'b00); o.fwd1 = 2'b01; o.mem = 32'd5;
    run_op("fwd_sub", o, 0, 0);
    o = mk(5'd0, 32'h0, 32'h0, 32'h20, 2'b00); o.br = 1'b1; o.cond = 2'b01;
    o.fl = 2'b10; o.pc = 32'h100;
    run_op("br_eq", o, 0, 0);

    run_op("mul_wrap", mk(5'd16, 32'h0001_0000, 32'h0001_0000, 32'h0, 2'b00), 33, 0);
    run_op("mul_7x6",  mk(5'd16, 32'd7,   32'd6, 32'h0, 2'b00), 33, 0);
    run_op("div_100",  mk(5'd17, 32'd100, 32'd7, 32'h0, 2'b00), 33, 0);
    run_op("rem_100",  mk(5'd18, 32'd100, 32'd7, 32'h0, 2'b00), 33, 0);
    run_op("div_zero", mk(5'd17, 32'd5,   32'd0, 32'h0, 2'b00), 1, 0);
    run_op("rem_zero", mk(5'd18, 32'd5,   32'd0, 32'h0, 2'b00), 1, 0);
    run_op("mul_hold", mk(5'd16, 32'd7,   32'd6, 32'h0, 2'b00), 33, 3);
    chk("hold_then_idle", {31'h0, ex_md_busy}, 32'h0);

    // Jump wins over branch and targets forwarded rs1
    o = mk(5'd0, 32'h1, 32'h2, 32'h40, 2'b00); o.jmp = 1'b1; o.br = 1'b1;
    o.cond = 2'b10; o.fl = 2'b10; o.fwd1 = 2'b10; o.wb = 32'h0000_0ABC; o.pc = 32'h200;
    run_op("jump_pri", o, 0, 0);

    // Flushed jump must not redirect
    o = mk(5'd0, 32'h44, 32'h0, 32'h0, 2'b00); o.jmp = 1'b1;
    drive(o); ex_flush_in = 1'b1;
    @(negedge clk);
    chk("flush_jump_redirect", {31'h0, ex_redirect}, 32'h0);
    @(posedge clk); #1;
    ex_flush_in = 1'b0; nop();

    // Flush during BUSY aborts the multiply
    drive(mk(5'd16, 32'd3, 32'd5, 32'h0, 2'b00));
    repeat (10) @(posedge clk);
    #1;
    chk("busy_before_flush", {31'h0, ex_md_busy}, 32'h1);
    ex_flush_in = 1'b1;
    @(negedge clk);
    chk("flush_stall", {31'h0, ex_stall}, 32'h0);
    chk("flush_redirect", {31'h0, ex_redirect}, 32'h0);
    @(posedge clk); #1;
    ex_flush_in = 1'b0; nop();
    chk("flush_md_busy", {31'h0, ex_md_busy}, 32'h0);
    @(negedge clk);
    chk("flush_after_stall", {31'h0, ex_stall}, 32'h0);
    @(posedge clk); #1;

    // Asynchronous reset mid-BUSY
    drive(mk(5'd17, 32'd1000, 32'd3, 32'h0, 2'b00));
    repeat (6) @(posedge clk);
    #3;
    nop();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {31'h0, ex_md_busy}, 32'h0);
    chk("rst_mid_stall", {31'h0, ex_stall}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Random single-cycle ops with forwarding, branches and jumps
    for (int i = 0; i < 60; i++) begin
      logic [4:0] code;
      code = 5'($urandom_range(0, 31));
      if (code >= 5'd16 && code <= 5'd18) code = 5'd9;
      o = mk(code, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)));
      if (i % 4 == 0) o.r2 = 32'($urandom_range(0, 40));
      o.fwd1 = 2'($urandom_range(0, 3)); o.fwd2 = 2'($urandom_range(0, 3));
      o.mem = $urandom; o.wb = $urandom; o.pc = $urandom;
      o.fl = 2'($urandom_range(0, 3)); o.cond = 2'($urandom_range(0, 3));
      o.br = ($urandom_range(0, 3) == 0); o.jmp = ($urandom_range(0, 5) == 0);
      run_op("rand_alu", o, 0, 0);
    end

    // Random mul/div/rem, including small and zero divisors
    for (int i = 0; i < 9; i++) begin
      logic [4:0] code;
      code = 5'(16 + (i % 3));
      o = mk(code, $urandom, $urandom, 32'h0, 2'b00);
      if (i >= 3) o.r2 = 32'($urandom_range(0, 300));
      if (i == 7) o.r2 = 32'h0;
      o.fwd1 = 2'($urandom_range(0, 3)); o.mem = $urandom; o.wb = $urandom;
      run_op("rand_md", o, (code != 5'd16 && model(o).st == 32'h0 && o.src == 2'b00) ? 1 : 33, 0);
    end

    nop();
    repeat (3) @(posedge clk);
    chk("sb_drained", sb.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
